// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes instruction memory.
// Optional checksum byte after the image is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] words_loaded,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_hold
);

  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StWlast, StDone, StErr
`ifdef IMEM_LOADER_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        n_lo_q;
  logic [15:0]       n_q;
  logic [15:0]       n_hdr;
  logic [1:0]        lane_q;
  logic [23:0]       word_q;
  logic [CNT_W-1:0]  words_q;
  logic              wr_en_q;
  logic [31:0]       wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              accepting;
  logic              xfer;
  logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  always_comb begin
    accepting = 1'b0;
    unique case (state_q)
      StHdr0, StHdr1, StData: accepting = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk:                  accepting = 1'b1;
`endif
      default:                accepting = 1'b0;
    endcase
  end

  assign xfer      = byte_valid && accepting;
  assign n_hdr     = {byte_data, n_lo_q};
  // words_q doubles as the index of the word currently being assembled
  assign last_word = (16'(words_q) == (n_q - 16'd1));

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StHdr0;
      end
      StHdr0: begin
        busy = 1'b1;
        if (xfer) state_d = StHdr1;
      end
      StHdr1: begin
        busy = 1'b1;
        if (xfer) begin
          if (n_hdr == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d = StDone;
`endif
          end else if (n_hdr > 16'(DEPTH)) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        busy = 1'b1;
        if (xfer && (lane_q == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StWlast;
`endif
        end
      end
      // Final word is being written; stream is closed but the load is not finished yet.
      StWlast: begin
        busy    = 1'b1;
        state_d = StDone;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        busy = 1'b1;
        if (xfer) state_d = (byte_data == sum_q) ? StDone : StErr;
      end
`endif
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_d = StHdr0;
      end
      StErr: begin
        error = 1'b1;
        if (start) state_d = StHdr0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      n_lo_q    <= 8'd0;
      n_q       <= 16'd0;
      lane_q    <= 2'd0;
      word_q    <= 24'd0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q     <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (state_d == StHdr0 && state_q != StHdr0) begin
        words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q   <= 8'd0;
`endif
      end
      if (state_q == StHdr0 && xfer) n_lo_q <= byte_data;
      if (state_q == StHdr1 && xfer) begin
        n_q    <= n_hdr;
        lane_q <= 2'd0;
      end
      if (state_q == StData && xfer) begin
        lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q  <= sum_q + byte_data;
`endif
        unique case (lane_q)
          2'd0: word_q[7:0]   <= byte_data;
          2'd1: word_q[15:8]  <= byte_data;
          2'd2: word_q[23:16] <= byte_data;
          default: begin
            wr_en_q   <= 1'b1;
            wr_data_q <= {byte_data, word_q};
            wr_addr_q <= {{(30-CNT_W){1'b0}}, words_q, 2'b00};
            words_q   <= words_q + CNT_W'(1);
          end
        endcase
      end
    end
  end

  assign byte_ready   = accepting;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-level reference model predicts every output each cycle,
// and literal expectations pin the scripted loads.
module tb_imem_loader;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CNT_W = 9;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [CNT_W-1:0] words_loaded;
  logic             busy;
  logic             done;
  logic             error;
  logic             cpu_hold;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .words_loaded(words_loaded), .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] wlog[$];
  logic [7:0]  stream[$];

  // Reference model: bytes still owed by the host, expected write, and load status (1 done, 2 err).
  int          m_need, m_cnt, m_n, m_words, m_stat;
  bit          m_busy, m_fin, m_pend;
  logic [31:0] m_addr, m_data, m_word;
  logic [7:0]  m_sum;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_need = 0; m_cnt = 0; m_n = 0; m_words = 0; m_stat = 0;
    m_busy = 0; m_fin = 0; m_pend = 0; m_word = 0; m_sum = 0;
  endfunction

  always @(negedge clk) begin
    logic [7:0] b;
    int k;
    bit nxt_pend;
    if (reset) begin
      model_reset();
      check("rst_byte_ready", 32'(byte_ready), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_words", 32'(words_loaded), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_cpu_hold", 32'(cpu_hold), 1);
    end else begin
      check("byte_ready", 32'(byte_ready), 32'(m_need != 0));
      check("wr_en", 32'(wr_en), 32'(m_pend));
      if (m_pend) begin
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
      end
      if (wr_en) begin
        check("wr_addr_align", 32'(wr_addr[1:0]), 0);
        check("wr_addr_max", 32'(wr_addr <= (DEPTH - 1) * 4), 1);
        wlog.push_back({wr_addr, wr_data});
      end
      check("words_loaded", 32'(words_loaded), 32'(m_words));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_stat == 1));
      check("error", 32'(error), 32'(m_stat == 2));
      check("cpu_hold", 32'(cpu_hold), 32'(m_stat != 1));

      if (m_fin) begin
        m_fin = 0; m_stat = 1; m_busy = 0;
      end
      nxt_pend = 0;
      if (start && !m_busy) begin
        m_need = 2; m_busy = 1; m_stat = 0; m_words = 0; m_cnt = 0; m_sum = 0; m_word = 0;
      end else if (byte_valid && m_need != 0) begin
        b = byte_data;
        m_need--;
        if (m_cnt == 0) begin
          m_n = int'(b);
        end else if (m_cnt == 1) begin
          m_n = m_n + 256 * int'(b);
          if (m_n > int'(DEPTH)) begin
            m_need = 0; m_stat = 2; m_busy = 0;
          end else begin
            m_need = 4 * m_n + CKS;
            if (m_need == 0) begin
              m_stat = 1; m_busy = 0;
            end
          end
        end else if (m_cnt < 2 + 4 * m_n) begin
          k = (m_cnt - 2) % 4;
          m_word = m_word | (32'(b) << (8 * k));
          m_sum = m_sum + b;
          if (k == 3) begin
            nxt_pend = 1;
            m_addr = 32'(m_words * 4);
            m_data = m_word;
            m_word = 0;
            m_words++;
            if (m_words == m_n && CKS == 0) m_fin = 1;
          end
        end else begin
          m_stat = (b == m_sum) ? 1 : 2;
          m_busy = 0;
        end
        m_cnt++;
      end
      m_pend = nxt_pend;
    end
  end

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int guard = 0;
    bit ok = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && guard < 20) begin
      idle(1);
      guard++;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    do begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 50);
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic run_load(input int gap_pct, input bit toggle, input int mid_gap_at, input int limit);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (stream[i]) begin
      if (limit >= 0 && i >= limit) break;
      if (i == mid_gap_at) idle(5);
      if (toggle) idle(1);
      send_byte(stream[i], gap_pct);
    end
  endtask

  task automatic add_cks();
    logic [7:0] s = 8'd0;
    if (CKS != 0) begin
      foreach (stream[i]) if (i >= 2) s = s + stream[i];
      stream.push_back(s);
    end
  endtask

  task automatic set_basic();
    logic [7:0] basic [14] = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01,
                               8'h20, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    stream.delete();
    foreach (basic[i]) stream.push_back(basic[i]);
    add_cks();
  endtask

  task automatic set_one_word();
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h00); stream.push_back(8'h13);
    stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    add_cks();
  endtask

  task automatic set_random(input int n);
    stream.delete();
    stream.push_back(8'(n)); stream.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    add_cks();
  endtask

  task automatic finish_checks(input string tag, input bit exp_done, input int exp_words);
    int i = 0;
    while (!(done || error) && i < 30) begin
      @(posedge clk); #1;
      i++;
    end
    check({tag, "_end_seen"}, 32'(done || error), 1);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(!exp_done));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_byte_ready"}, 32'(byte_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_basic_log(input string tag);
    check({tag, "_nwrites"}, 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      check({tag, "_w0"}, wlog[0][31:0], 32'h00100093);
      check({tag, "_a0"}, wlog[0][63:32], 32'h0);
      check({tag, "_w1"}, wlog[1][31:0], 32'h00200113);
      check({tag, "_a1"}, wlog[1][63:32], 32'h4);
      check({tag, "_w2"}, wlog[2][31:0], 32'h00100073);
      check({tag, "_a2"}, wlog[2][63:32], 32'h8);
    end
  endtask

  task automatic check_one_word_log(input string tag);
    check({tag, "_nwrites"}, 32'(wlog.size()), 1);
    if (wlog.size() == 1) begin
      check({tag, "_addr"}, wlog[0][63:32], 32'h0);
      check({tag, "_data"}, wlog[0][31:0], 32'h00000013);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("init_cpu_hold", 32'(cpu_hold), 1);
    check("init_done", 32'(done), 0);
    check("init_byte_ready", 32'(byte_ready), 0);

    set_basic(); wlog.delete();
    run_load(0, 0, -1, -1);
    finish_checks("basic", 1, 3);
    check_basic_log("basic");

    set_basic(); wlog.delete();
    run_load(0, 1, 4, -1);
    finish_checks("throttle", 1, 3);
    check_basic_log("throttle");

    stream.delete(); stream.push_back(8'h00); stream.push_back(8'h00); add_cks(); wlog.delete();
    run_load(0, 0, -1, -1);
    check("zero_done_next", 32'(done), 1);
    finish_checks("zero", 1, 0);
    check("zero_nwrites", 32'(wlog.size()), 0);

    stream.delete(); stream.push_back(8'h01); stream.push_back(8'h01); wlog.delete();
    run_load(0, 0, -1, -1);
    finish_checks("oversize", 0, 0);
    check("oversize_nwrites", 32'(wlog.size()), 0);
    set_one_word(); wlog.delete();
    run_load(0, 0, -1, -1);
    finish_checks("after_err", 1, 1);
    check_one_word_log("after_err");

    set_random(2); wlog.delete();
    run_load(0, 0, -1, 8);
    reset = 1'b1;
    #1;
    check("midrst_byte_ready", 32'(byte_ready), 0);
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_words", 32'(words_loaded), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_error", 32'(error), 0);
    check("midrst_cpu_hold", 32'(cpu_hold), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    set_one_word(); wlog.delete();
    run_load(0, 0, -1, -1);
    finish_checks("reload", 1, 1);
    check_one_word_log("reload");

    if (CKS != 0) begin
      set_one_word();
      stream[6] = 8'h14;
      run_load(0, 0, -1, -1);
      finish_checks("cks_bad", 0, 1);
    end

    for (int r = 0; r < 12; r++) begin
      n = (r == 11) ? int'($urandom_range(DEPTH + 40, DEPTH + 1)) : int'($urandom_range(12, 1));
      if (n > int'(DEPTH)) begin
        stream.delete(); stream.push_back(8'(n)); stream.push_back(8'(n >> 8));
        run_load(0, 0, -1, -1);
        finish_checks("rand_over", 0, 0);
      end else begin
        set_random(n);
        run_load(int'($urandom_range(3)) * 15, 0, -1, -1);
        finish_checks("rand", 1, n);
      end
    end

    set_random(int'(DEPTH)); wlog.delete();
    run_load(0, 0, -1, -1);
    finish_checks("full", 1, int'(DEPTH));
    check("full_nwrites", 32'(wlog.size()), DEPTH);
    if (wlog.size() > 0) check("full_last_addr", wlog[wlog.size() - 1][63:32], (DEPTH - 1) * 4);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
